spi_sram_responder: RTL and testbench
=====================================

# spi_sram_responder

SPI slave that emulates a 23LC1024-style serial SRAM in sequential mode, answering the READ/WRITE/RDMR command stream issued by `spi_controller` on the external memory port. Backed by an internal byte array of `DEPTH` entries, it closes the loop on the memory side for FPGA prototyping and for self-contained system simulation of the Levenshtein engine. It is the responder for `spi_controller`.

## Interface
- `DEPTH`, 256: bytes of backing storage; power of two, minimum 16.
- `AW`, $clog2(DEPTH): internal address width; derived, not overridden.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset: one clock; reset is asynchronous and active-low.
- `spi_ss_n`  in  1  chip select, active low, asynchronous to `clk_i`.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk_i`.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `spi_miso_oe`  out  1  high while a READ or RDMR data phase is active.

## Operation
- `spi_ss_n`, `spi_sck` and `spi_mosi` each pass through a 2-flop synchronizer; sck rise and fall are detected from the synchronized copy.
- `spi_ss_n` high (synchronized) forces the `IDLE` state at once, from any state.
- Frame layout: 8-bit opcode, then 24-bit address for READ/WRITE, then data bytes. All fields are sampled on sck rise.
- Opcodes:
  - 0x03 READ
  - 0x02 WRITE
  - 0x05 RDMR
  - anything else: `IGNORE` until `spi_ss_n` rises.
- Address: only bits [AW-1:0] are used; upper bits are discarded, so addresses alias modulo `DEPTH`.
- States:
  - `IDLE` -> `CMD` on ss_n fall.
  - `CMD`: after 8 bits, -> `ADDR` (READ/WRITE), `RDMR`, or `IGNORE`.
  - `ADDR`: after 24 bits, -> `WDATA` or `RDATA`.
  - `WDATA`, `RDATA`, `RDMR`, `IGNORE`: stay until ss_n rises.
- WRITE: on the 8th data rise of each byte, write `mem[ptr]`, then `ptr <= ptr+1`, wrapping at `DEPTH-1` -> 0. A partial byte at ss_n rise is discarded; no write occurs.
- READ: `mem[ptr]` is loaded into the tx shift register in the cycle after the last address bit. Bit 7 is driven on `spi_miso` before the next sck rise. The register shifts on each sck fall. After 8 bits, `ptr` increments with wrap and the next byte is loaded.
- RDMR: returns 0x40 (sequential mode) repeatedly.
- Memory contents are not reset.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, state `IDLE`, bit counter 0, `ptr` 0.
- Constraint: f_sck <= f_clk_i/6; each sck high and low phase >= 3 clk_i.
- Input latency: 2 clk_i synchronizer + 1 edge-detect stage.
- `spi_miso` changes <= 4 clk_i after an sck fall. The first data bit is valid <= 4 clk_i after the final address rise.
- `spi_miso_oe` asserts in the same cycle as the first data bit. It drops, together with `spi_miso`, 3 clk_i after ss_n rises.
- A write to memory occurs 1 clk_i after the synchronized 8th rise.
- Reset mid-frame: the byte in flight is lost, and the responder waits for a new ss_n fall. Falling-edge detection is not armed if ss_n is already low when reset deasserts.
- Simultaneous ss_n rise and sck edge: ss_n wins, and the edge is ignored.

## Structure
- Shared package `spi_sram_pkg`: opcode constants (`OP_READ`, `OP_WRITE`, `OP_RDMR`), `MODE_SEQ`=0x40, and the state enumeration.
- Sub-module `spi_input_sync`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated once per input.
- Top level: FSM, 5-bit bit counter, rx/tx shift registers, `ptr`, and the memory array.

## Test plan
- WRITE 0x02, addr 0x000010, data 0xA5 0x5A; then READ 0x03 of addr 0x000010 for 2 bytes -> MISO returns 0xA5, 0x5A.
- WRITE 4 bytes 0x11..0x44 starting at `DEPTH-2`; read 4 bytes from `DEPTH-2` -> 0x11 0x22 0x33 0x44; `mem[0]`=0x33 (wrap).
- RDMR 0x05, clock 16 bits -> 0x40 0x40; `spi_miso_oe` high only during the data bits.
- Opcode 0x9F followed by 32 bits -> `spi_miso_oe` stays 0 and memory is unchanged.
- WRITE to addr 0x000020 with only 5 data bits, then ss_n high -> `mem[0x20]` keeps its prior value.
- Assert `rst_ni` low mid-READ, release, and run a full READ -> outputs are 0 during reset, and the second frame returns correct data.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Opcodes, mode byte, bit-count limits and FSM states
// shared by the SPI SRAM responder and its bench.
package spi_sram_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDMR  = 8'h05;
   localparam logic [7:0] MODE_SEQ = 8'h40;

   localparam logic [4:0] BYTE_LAST = 5'd7;
   localparam logic [4:0] ADDR_LAST = 5'd23;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      RDATA,
      RDMR,
      IGNORE
   } state_t;

endpackage

// File: rtl/spi_sram_responder_sync.sv
// Two-flop synchronizer for one SPI pin with
// single-cycle rise/fall pulses from the synced copy.
module spi_input_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta;
   logic prev;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta <= 1'b0;
         q    <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
         prev <= q;
      end
   end

   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_sram_responder.sv
// 23LC1024-style SPI SRAM responder, sequential mode,
// backed by a DEPTH-byte internal array.
module spi_sram_responder
   import spi_sram_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic spi_ss_n,
   input  logic spi_sck,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic ss_q, ss_rise, ss_fall;
   logic sck_q, sck_rise, sck_fall;
   logic mosi_q, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_input_sync u_ss (
      .clk_i(clk_i), .rst_ni(rst_ni), .d(spi_ss_n),
      .q(ss_q), .rise(ss_rise), .fall(ss_fall)
   );
   spi_input_sync u_sck (
      .clk_i(clk_i), .rst_ni(rst_ni), .d(spi_sck),
      .q(sck_q), .rise(sck_rise), .fall(sck_fall)
   );
   spi_input_sync u_mosi (
      .clk_i(clk_i), .rst_ni(rst_ni), .d(spi_mosi),
      .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sync = &{1'b0, ss_rise, sck_q, mosi_rise, mosi_fall};

   state_t        state;
   logic [4:0]    bit_cnt;
   logic [7:0]    rx;
   logic [7:0]    tx;
   logic [AW-1:0] ptr;
   logic          is_rd;
   logic          load;
   logic [7:0]    mem [DEPTH];

   logic [7:0] rx_byte;
   logic [7:0] rd_byte;
   logic       wr_en;

   assign rx_byte = {rx[6:0], mosi_q};
   assign rd_byte = (state == RDMR) ? MODE_SEQ : mem[ptr];
   assign wr_en   = sck_rise & ~ss_q & (state == WDATA)
                  & (bit_cnt == BYTE_LAST);

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[ptr] <= rx_byte;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         rx          <= '0;
         tx          <= '0;
         ptr         <= '0;
         is_rd       <= 1'b0;
         load        <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else if (ss_q) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         load        <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else begin
         load <= 1'b0;
         if (load) begin
            tx          <= rd_byte;
            spi_miso    <= rd_byte[7];
            spi_miso_oe <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  rx      <= rx_byte;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == BYTE_LAST) begin
                     bit_cnt <= '0;
                     is_rd   <= (rx_byte == OP_READ);
                     unique case (1'b1)
                        (rx_byte == OP_READ),
                        (rx_byte == OP_WRITE): state <= ADDR;
                        (rx_byte == OP_RDMR): begin
                           state <= RDMR;
                           load  <= 1'b1;
                        end
                        default: state <= IGNORE;
                     endcase
                  end
               end
            end
            ADDR: begin
               // Shifting the whole 24-bit field leaves the low AW bits.
               if (sck_rise) begin
                  ptr     <= {ptr[AW-2:0], mosi_q};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == ADDR_LAST) begin
                     bit_cnt <= '0;
                     state   <= is_rd ? RDATA : WDATA;
                     load    <= is_rd;
                  end
               end
            end
            WDATA, RDATA, RDMR: begin
               if (sck_rise) begin
                  rx      <= rx_byte;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == BYTE_LAST) begin
                     bit_cnt <= '0;
                     if (state != RDMR) ptr <= ptr + AW'(1);
                  end
               end else if (sck_fall && state != WDATA) begin
                  // A fall at a byte boundary presents the next byte.
                  if (bit_cnt == '0) begin
                     tx       <= rd_byte;
                     spi_miso <= rd_byte[7];
                  end else begin
                     tx       <= {tx[6:0], 1'b0};
                     spi_miso <= tx[6];
                  end
               end
            end
            IGNORE: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: random and
// directed SPI frames against a byte-array memory model.
module tb_spi_sram_responder;
   import spi_sram_pkg::*;

   localparam int DEPTH = 256;
   localparam int HALF  = 4;

   logic clk_i    = 1'b0;
   logic rst_ni   = 1'b1;
   logic spi_ss_n = 1'b1;
   logic spi_sck  = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   logic spi_miso_oe;

   int checks = 0;
   int errors = 0;
   logic data_phase = 1'b0;

   typedef struct {
      logic [7:0] val;
      bit         known;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [int];

   spi_sram_responder #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .spi_ss_n(spi_ss_n),
      .spi_sck(spi_sck),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso),
      .spi_miso_oe(spi_miso_oe)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: assemble MISO bytes as the master samples them.
   int         mbits = 0;
   logic [7:0] msr   = '0;
   always @(posedge spi_sck or posedge spi_ss_n) begin
      if (spi_ss_n) begin
         mbits = 0;
      end else begin
         check("oe_phase", 8'(spi_miso_oe), 8'(data_phase));
         if (spi_miso_oe) begin
            msr = {msr[6:0], spi_miso};
            mbits++;
            if (mbits == 8) begin
               mbits = 0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_underflow actual=%h required=none", msr);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  if (e.known) check("rd_byte", msr, e.val);
               end
            end
         end
      end
   end

   task automatic send_bit(input logic b, input logic rd);
      spi_mosi   = b;
      data_phase = rd;
      repeat (HALF) @(negedge clk_i);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk_i);
      spi_sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input logic rd);
      for (int i = 7; i >= 0; i--) send_bit(v[i], rd);
   endtask

   task automatic begin_frame(input logic [7:0] op, input logic [23:0] addr,
                              input bit with_addr);
      spi_ss_n = 1'b0;
      repeat (HALF) @(negedge clk_i);
      send_byte(op, 1'b0);
      if (with_addr)
         for (int i = 23; i >= 0; i--) send_bit(addr[i], 1'b0);
   endtask

   task automatic end_frame(input bit was_rd);
      data_phase = 1'b0;
      repeat (HALF) @(negedge clk_i);
      spi_ss_n = 1'b1;
      repeat (2) @(negedge clk_i);
      if (was_rd) check("oe_hold", 8'(spi_miso_oe), 8'd1);
      @(negedge clk_i);
      check("oe_drop", 8'(spi_miso_oe), 8'd0);
      check("miso_drop", 8'(spi_miso), 8'd0);
      repeat (HALF) @(negedge clk_i);
   endtask

   task automatic do_write(input logic [23:0] addr, input logic [7:0] d[$],
                           input int part);
      begin_frame(OP_WRITE, addr, 1'b1);
      foreach (d[i]) begin
         send_byte(d[i], 1'b0);
         model[(int'(addr) + i) % DEPTH] = d[i];
      end
      for (int k = 0; k < part; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      end_frame(1'b0);
   endtask

   task automatic do_read(input logic [23:0] addr, input int n);
      begin_frame(OP_READ, addr, 1'b1);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         int   idx;
         idx     = (int'(addr) + i) % DEPTH;
         e.known = model.exists(idx);
         e.val   = e.known ? model[idx] : 8'h00;
         sb.push_back(e);
         send_byte(8'($urandom), 1'b1);
      end
      end_frame(n > 0);
   endtask

   task automatic do_rdmr(input int n);
      begin_frame(OP_RDMR, 24'h0, 1'b0);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.known = 1'b1;
         e.val   = MODE_SEQ;
         sb.push_back(e);
         send_byte(8'($urandom), 1'b1);
      end
      end_frame(1'b1);
   endtask

   task automatic do_ignore(input logic [7:0] op, input logic [31:0] payload);
      begin_frame(op, 24'h0, 1'b0);
      for (int i = 31; i >= 0; i--) send_bit(payload[i], 1'b0);
      end_frame(1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  d[$];
      logic [7:0]  op;
      logic [23:0] a;
      int          n;
      int          kind;

      @(negedge clk_i);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_miso", 8'(spi_miso), 8'd0);
      check("rst_oe", 8'(spi_miso_oe), 8'd0);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);

      d = '{8'hA5, 8'h5A};
      do_write(24'h000010, d, 0);
      do_read(24'h000010, 2);

      d = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_write(24'(DEPTH - 2), d, 0);
      do_read(24'(DEPTH - 2), 4);
      do_read(24'h000000, 1);

      do_rdmr(2);

      d = '{8'h3C};
      do_write(24'h000020, d, 0);
      do_ignore(8'h9F, 32'h0000_10FF);
      do_read(24'h000010, 2);

      d.delete();
      do_write(24'h000020, d, 5);
      do_read(24'h000020, 1);

      // Reset in the middle of a READ data byte.
      begin_frame(OP_READ, 24'h000010, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
      data_phase = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("midrst_miso", 8'(spi_miso), 8'd0);
      check("midrst_oe", 8'(spi_miso_oe), 8'd0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      send_byte(OP_RDMR, 1'b0);
      send_byte(8'hA5, 1'b0);
      end_frame(1'b0);
      do_read(24'h000010, 2);

      for (int t = 0; t < 24; t++) begin
         a    = {16'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         n    = int'($urandom_range(1, 4));
         kind = int'($urandom_range(0, 5));
         d.delete();
         case (kind)
            0, 1: begin
               for (int k = 0; k < n; k++) d.push_back(8'($urandom));
               do_write(a, d, (kind == 1) ? 3 : 0);
            end
            2, 3: do_read(a, n);
            4: do_rdmr(n);
            default: begin
               op = 8'($urandom);
               if (op == OP_READ || op == OP_WRITE || op == OP_RDMR) op = 8'hFF;
               do_ignore(op, 32'($urandom));
            end
         endcase
      end

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_empty actual=%0d required=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
